// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a memory-stage data port and a fetch port share
// one 2048-word memory. Data normally wins; fetch is forced through once data has
// taken STARVE_MAX consecutive grants while fetch was waiting. Every output is a
// register, so all responses appear one edge after the state that produces them.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,  // memory read latency, 1..15
  parameter int unsigned STARVE_MAX = 4   // data grants tolerated while fetch waits, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  // Data (memory-stage) requester
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [63:0] i_d_addr,
  input  logic [63:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_done,
  output logic [63:0] o_d_rdata,
  output logic        o_d_err,
  // Fetch requester (read only)
  input  logic        i_f_req,
  input  logic [63:0] i_f_addr,
  output logic        o_f_gnt,
  output logic        o_f_done,
  output logic [63:0] o_f_rdata,
  output logic        o_f_err,
  // Memory port
  output logic        o_m_en,
  output logic        o_m_we,
  output logic [10:0] o_m_addr,
  output logic [63:0] o_m_wdata,
  input  logic [63:0] i_m_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StErr, StDone} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_starve;
  logic        r_own_f;
  logic        r_d_gnt;
  logic        r_d_done;
  logic [63:0] r_d_rdata;
  logic        r_d_err;
  logic        r_f_gnt;
  logic        r_f_done;
  logic [63:0] r_f_rdata;
  logic        r_f_err;
  logic        r_m_en;
  logic        r_m_we;
  logic [10:0] r_m_addr;
  logic [63:0] r_m_wdata;

  logic        w_pick_f;
  logic [63:0] w_addr;
  logic        w_we;
  logic [63:0] w_wdata;
  logic        w_addr_err;
  logic [63:0] w_cap;

  // Arbitration and selection of the winning request's fields.
  always_comb begin
    w_pick_f   = i_f_req && (!i_d_req || (r_starve == 4'(STARVE_MAX)));
    w_addr     = w_pick_f ? i_f_addr : i_d_addr;
    w_we       = w_pick_f ? 1'b0 : i_d_we;
    w_wdata    = w_pick_f ? 64'd0 : i_d_wdata;
    w_addr_err = (w_addr[63:11] != '0);
    // Writes report zero read data.
    w_cap      = r_m_we ? 64'd0 : i_m_rdata;
  end

  // Main FSM: owns all state and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_starve  <= '0;
      r_own_f   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_d_done  <= 1'b0;
      r_d_rdata <= '0;
      r_d_err   <= 1'b0;
      r_f_gnt   <= 1'b0;
      r_f_done  <= 1'b0;
      r_f_rdata <= '0;
      r_f_err   <= 1'b0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_d_req || i_f_req) begin
            r_own_f <= w_pick_f;
            r_d_gnt <= !w_pick_f;
            r_f_gnt <= w_pick_f;
            // Starve count only grows while fetch is actually being passed over.
            if (w_pick_f || !i_f_req) begin
              r_starve <= '0;
            end else if (r_starve != 4'(STARVE_MAX)) begin
              r_starve <= r_starve + 4'd1;
            end
            if (w_addr_err) begin
              r_state <= StErr;
            end else begin
              r_state   <= StAccess;
              r_cnt     <= 4'(MEM_LAT - 1);
              r_m_en    <= 1'b1;
              r_m_we    <= w_we;
              r_m_addr  <= w_addr[10:0];
              r_m_wdata <= w_wdata;
            end
          end
        end
        StAccess: begin
          if (r_cnt == 4'd0) begin
            r_state   <= StDone;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            if (r_own_f) begin
              r_f_done  <= 1'b1;
              r_f_rdata <= w_cap;
            end else begin
              r_d_done  <= 1'b1;
              r_d_rdata <= w_cap;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StErr: begin
          r_state <= StDone;
          if (r_own_f) begin
            r_f_done <= 1'b1;
            r_f_err  <= 1'b1;
          end else begin
            r_d_done <= 1'b1;
            r_d_err  <= 1'b1;
          end
        end
        StDone: begin
          r_state   <= StIdle;
          r_d_gnt   <= 1'b0;
          r_d_done  <= 1'b0;
          r_d_rdata <= '0;
          r_d_err   <= 1'b0;
          r_f_gnt   <= 1'b0;
          r_f_done  <= 1'b0;
          r_f_rdata <= '0;
          r_f_err   <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_d_gnt   = r_d_gnt;
  assign o_d_done  = r_d_done;
  assign o_d_rdata = r_d_rdata;
  assign o_d_err   = r_d_err;
  assign o_f_gnt   = r_f_gnt;
  assign o_f_done  = r_f_done;
  assign o_f_rdata = r_f_rdata;
  assign o_f_err   = r_f_err;
  assign o_m_en    = r_m_en;
  assign o_m_we    = r_m_we;
  assign o_m_addr  = r_m_addr;
  assign o_m_wdata = r_m_wdata;

endmodule
